// File: rtl/vedic_prod_drain.sv
// Drain FIFO for the Vedic multiplier product stream.
// First-word-fall-through, valid/ready out, sticky overflow flag.
module vedic_prod_drain #(
   parameter int DW        = 18,
   parameter int DEPTH     = 4,
   parameter int AF_MARGIN = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DW-1:0]              in_data,
   output logic                       in_ready,
   output logic                       almost_full,
   output logic                       out_valid,
   output logic [DW-1:0]              out_data,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf_err,
   input  logic                       clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_TH = CW'(DEPTH - AF_MARGIN);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          ovf_q;
   logic          push;
   logic          pop;
   logic          drop;

   // Handshake terms; a full FIFO still accepts when its head leaves.
   always_comb begin
      in_ready    = (cnt != FULL) | out_ready;
      out_valid   = (cnt != '0);
      push        = in_valid & in_ready;
      pop         = out_valid & out_ready;
      drop        = in_valid & ~in_ready;
      almost_full = (cnt >= AF_TH);
      out_data    = mem[rd_ptr];
      count       = cnt;
      ovf_err     = ovf_q;
   end

   // Storage is left unreset; only pointers and count gate visibility.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Occupancy tracks push minus pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (push && !pop)
         cnt <= cnt + 1'b1;
      else if (pop && !push)
         cnt <= cnt - 1'b1;
   end

   // Sticky drop flag; a fresh drop beats a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_q <= 1'b0;
      else if (drop)
         ovf_q <= 1'b1;
      else if (clr_err)
         ovf_q <= 1'b0;
   end

endmodule
